// File: rtl/ex_mem_elastic_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush, and control gating on bubbles.
// EX_MEM_SKID_EN selects a 2-entry skid buffer (registered o_ready); otherwise single entry with combinational o_ready.
module ex_mem_elastic_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_wreg,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_wdata,
  output logic [REG_W-1:0]  o_wreg,
  output logic [CTRL_W-1:0] o_ctrl
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
    logic [CTRL_W-1:0] ctrl;
  } pay_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  pay_t   main_q;
  pay_t   in_pay;
  logic   acc;
  logic   rel;

  assign in_pay  = '{alu: i_alu, wdata: i_wdata, wreg: i_wreg, ctrl: i_ctrl};
  assign o_valid = (state != EMPTY);
  assign acc     = i_valid && o_ready;
  assign rel     = o_valid && i_ready;

  assign o_alu   = main_q.alu;
  assign o_wdata = main_q.wdata;
  assign o_wreg  = main_q.wreg;
  // A bubble must never write memory or the register file.
  assign o_ctrl  = o_valid ? main_q.ctrl : '0;

`ifdef EX_MEM_SKID_EN
  pay_t skid_q;

  // Depends only on state so the upstream never sees a path from i_ready.
  assign o_ready = (state != TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (i_flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_pay;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && rel) begin
            main_q <= in_pay;
          end else if (acc) begin
            skid_q <= in_pay;
            state  <= TWO;
          end else if (rel) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (rel) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`else
  assign o_ready = !o_valid || i_ready;

  // With one entry an accept while full always coincides with a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
    end else if (i_flush) begin
      state <= EMPTY;
    end else if (acc) begin
      main_q <= in_pay;
      state  <= ONE;
    end else if (rel) begin
      state <= EMPTY;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Directed bench for ex_mem_elastic_reg; expectations follow EX_MEM_SKID_EN when it is defined.
module tb_ex_mem_elastic_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_flush = 1'b0;
  logic [15:0] i_alu = '0;
  logic [15:0] i_wdata = '0;
  logic [4:0]  i_wreg = '0;
  logic [3:0]  i_ctrl = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_alu;
  logic [15:0] o_wdata;
  logic [4:0]  o_wreg;
  logic [3:0]  o_ctrl;

  int checks = 0;
  int errors = 0;

  ex_mem_elastic_reg #(.DATA_W(16), .REG_W(5), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_alu(i_alu), .i_wdata(i_wdata), .i_wreg(i_wreg), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu(o_alu), .o_wdata(o_wdata),
    .o_wreg(o_wreg), .o_ctrl(o_ctrl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [3:0] ctrl);
    i_valid = v;
    i_alu   = alu;
    i_wdata = alu ^ 16'hFFFF;
    i_wreg  = alu[4:0];
    i_ctrl  = ctrl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'h1234, 4'hF);
    step();
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", o_ctrl); end
    checks++; if ({o_alu, o_wdata, o_wreg} !== 37'h0) begin errors++; $display("FAIL reset_payload got %h/%h/%h exp 0", o_alu, o_wdata, o_wreg); end
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", o_valid); end
  endtask

  task automatic test_stream();
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 16'(k), 4'b0001);
      step();
      checks++;
      if (o_valid !== 1'b1 || o_alu !== 16'(k) || o_wdata !== (16'(k) ^ 16'hFFFF) || o_ctrl !== 4'b0001)
        begin errors++; $display("FAIL stream_%0d got v=%b alu=%h wd=%h ctrl=%h exp v=1 alu=%h", k, o_valid, o_alu, o_wdata, o_ctrl, 16'(k)); end
    end
    drive(1'b0, 16'h0, 4'h0);
    step();
    checks++; if (o_valid !== 1'b0 || o_ctrl !== 4'h0) begin errors++; $display("FAIL stream_drain got v=%b ctrl=%h exp 0/0", o_valid, o_ctrl); end
    checks++; if (o_wreg !== 5'd8) begin errors++; $display("FAIL stream_hold_wreg got %h exp 08", o_wreg); end
  endtask

  task automatic test_stall();
    i_ready = 1'b1;
    drive(1'b1, 16'hAAAA, 4'b0001);
    step();
    drive(1'b1, 16'hBBBB, 4'b0001);
    i_ready = 1'b0;
`ifdef EX_MEM_SKID_EN
    step();
    drive(1'b0, 16'h0, 4'h0);
`else
    #1;
`endif
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_alu !== 16'hAAAA || o_valid !== 1'b1 || o_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold_%0d got alu=%h v=%b rdy=%b exp AAAA/1/0", c, o_alu, o_valid, o_ready); end
      step();
    end
    i_ready = 1'b1;
    #1;
`ifndef EX_MEM_SKID_EN
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_comb got %b exp 1", o_ready); end
`endif
    step();
    drive(1'b0, 16'h0, 4'h0);
    checks++; if (o_alu !== 16'hBBBB || o_valid !== 1'b1 || o_ready !== 1'b1)
      begin errors++; $display("FAIL stall_second got alu=%h v=%b rdy=%b exp BBBB/1/1", o_alu, o_valid, o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_flush_full();
    i_ready = 1'b1;
    drive(1'b1, 16'h0A01, 4'b0101);
    step();
    drive(1'b1, 16'h0A02, 4'b0101);
    i_ready = 1'b0;
`ifdef EX_MEM_SKID_EN
    step();
`else
    #1;
`endif
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_ready got %b exp 0", o_ready); end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_ctrl !== 4'h0 || o_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got v=%b ctrl=%h rdy=%b exp 0/0/1", o_valid, o_ctrl, o_ready); end
    i_ready = 1'b1;
    drive(1'b1, 16'h00CC, 4'b0001);
    step();
    drive(1'b0, 16'h0, 4'h0);
    checks++; if (o_valid !== 1'b1 || o_alu !== 16'h00CC) begin errors++; $display("FAIL flush_next got v=%b alu=%h exp 1/00CC", o_valid, o_alu); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_alone got v=%b alu=%h exp v=0", o_valid, o_alu); end
  endtask

  task automatic test_flush_accept();
    i_ready = 1'b1;
    drive(1'b1, 16'h0A0A, 4'b0001);
    step();
    drive(1'b1, 16'h0DDD, 4'b0100);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    checks++; if (o_valid !== 1'b0 || o_ctrl[2] !== 1'b0) begin errors++; $display("FAIL flush_acc got v=%b ctrl=%h exp 0/0", o_valid, o_ctrl); end
    step();
    checks++; if (o_valid !== 1'b0 || o_alu !== 16'h0A0A) begin errors++; $display("FAIL flush_acc_drop got v=%b alu=%h exp 0/0A0A", o_valid, o_alu); end
  endtask

  task automatic test_ready_path();
    i_ready = 1'b1;
    drive(1'b1, 16'h00EE, 4'b0001);
    step();
    drive(1'b0, 16'h0, 4'h0);
    i_ready = 1'b0;
    #1;
`ifdef EX_MEM_SKID_EN
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_stall got %b exp 1", o_ready); end
`else
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_stall got %b exp 0", o_ready); end
`endif
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_go got %b exp 1", o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ready_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_reset_full();
    i_ready = 1'b1;
    drive(1'b1, 16'h0F0F, 4'b1111);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    checks++; if (o_valid !== 1'b0 || o_alu !== 16'h0 || o_ctrl !== 4'h0)
      begin errors++; $display("FAIL reset_full got v=%b alu=%h ctrl=%h exp 0/0/0", o_valid, o_alu, o_ctrl); end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_accept();
    test_ready_path();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_mem_elastic_reg.md
# ex_mem_elastic_reg

Parametrised, flow-controlled EX→MEM pipeline register that carries the ALU result, store data, destination register and MEM/WB control bits between the execute and memory stages. It adds a valid/ready handshake, stall absorption through an internal 2-entry skid buffer, and a synchronous flush for branch/exception squash. Control bits are forced low on bubbles so that a flushed or empty slot can never write memory or the register file. It sits between the ALU/forwarding mux (upstream) and the data-memory interface (downstream).

## Interface
- DATA_W, 16, width of ALU result and store data
- REG_W, 5, width of destination register index
- CTRL_W, 4, control bits; bit0 REGWrite, bit1 MEMtoREG, bit2 MEMWrite, bit3 MEMRead
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- i_valid  in  1  upstream slot holds a live instruction
- o_ready  out  1  stage can accept this cycle
- i_flush  in  1  squash all held and incoming instructions
- i_alu  in  DATA_W  ALU result
- i_wdata  in  DATA_W  store data
- i_wreg  in  REG_W  destination register
- i_ctrl  in  CTRL_W  MEM/WB control
- o_valid  out  1  output slot live
- i_ready  in  1  downstream (MEM) accepts this cycle
- o_alu, o_wdata  out  DATA_W  registered payload
- o_wreg  out  REG_W  registered destination
- o_ctrl  out  CTRL_W  registered control, all-zero whenever o_valid=0

## Operation
- Accept: i_valid && o_ready. Release: o_valid && i_ready.
- Storage: main entry (drives outputs) and skid entry, each payload plus valid.
- States: EMPTY (neither valid), ONE (main valid), TWO (both valid).
  - EMPTY: accept → ONE, main ← input.
  - ONE: accept & release → ONE, main ← input; accept only → TWO, skid ← input; release only → EMPTY.
  - TWO: release → ONE, main ← skid; accept impossible.
- o_ready = (state != TWO); depends only on registered state, never on i_ready.
- Flush: next state EMPTY, both valids cleared; an accept in the same cycle is discarded; a release in the same cycle still counts as consumed. Flush overrides all other transitions.
- Payload fields of an emptied entry hold their last value; o_ctrl is gated by o_valid.
- rst while any entry is valid discards both entries.

## Timing
- Latency: accepted input appears on outputs with o_valid=1 the next cycle (state EMPTY or ONE-with-release).
- Throughput: 1 instruction/cycle while i_ready=1.
- One stall cycle (i_ready=0) is absorbed by the skid buffer; o_ready drops the cycle after the skid entry fills and rises the cycle after it drains.
- Ordering strictly FIFO; no instruction duplicated or dropped except by flush/rst.
- Reset values: o_valid=0, o_ready=1, o_alu=0, o_wdata=0, o_wreg=0, o_ctrl=0, state EMPTY, skid payload 0.
- Inputs are ignored while rst=1.

## Configuration
- EX_MEM_SKID_EN defined: 2-entry skid behaviour as above; o_ready registered.
- Not defined: single entry only, states EMPTY/ONE; o_ready = !o_valid || i_ready (combinational through i_ready); accept & release in ONE reloads main; flush, reset, and gating rules unchanged.

## Test plan
- Reset: assert rst 2 cycles with i_valid=1, i_ctrl=4'hF → o_valid=0, o_ctrl=0, all payload 0, o_ready=1 after release.
- Streaming: i_ready=1, push alu=16'h0001..16'h0008 back-to-back → same values out in order, one cycle delay, no bubbles.
- Stall: push A=16'hAAAA, B=16'hBBBB, drop i_ready 3 cycles → o_alu holds AAAA, o_ready=0 from cycle after B; on i_ready=1, AAAA then BBBB, o_ready back to 1.
- Flush in TWO with i_ctrl=4'b0101 held → next cycle o_valid=0, o_ctrl=0, o_ready=1; subsequent push C=16'h00CC emerges alone.
- Flush with simultaneous accept of D=16'h0DDD and release → D never appears; MEMWrite never asserted.
- Without EX_MEM_SKID_EN: i_ready=0 with o_valid=1 → o_ready=0 same cycle; i_ready=1 → o_ready=1 combinationally, throughput 1/cycle.
